// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: samples the core's retire stream into a FIFO under
// arm/trigger/limit control and drains it through a valid/ready reader port.
module commit_trace_buffer #(
  parameter int unsigned DEPTH         = 16,
  parameter bit          STALL_ON_FULL = 1'b0,
  parameter int unsigned SEQ_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic [15:0]              capture_limit,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic [4:0]               commit_rd,
  input  logic                     commit_we,
  input  logic [31:0]              commit_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_instr,
  output logic [4:0]               trace_rd,
  output logic                     trace_we,
  output logic [31:0]              trace_wdata,
  output logic                     stall_req,
  output logic [1:0]               state,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_e;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [4:0]       rd;
    logic             we;
    logic [31:0]      wdata;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [15:0]      obs_q, obs_d;
  logic [15:0]      drop_q, drop_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;

  logic   full_c;
  logic   pop_c;
  logic   trig_hit_c;
  logic   capture_c;
  logic   push_ok_c;
  entry_t wr_entry_c;

  // Capture qualification; arm suppresses any same-cycle commit or pop.
  always_comb begin
    full_c     = (level_q == LVL_W'(DEPTH));
    pop_c      = valid_q && trace_ready;
    trig_hit_c = !trig_en || (commit_pc == trig_pc);
    capture_c  = !arm && commit_valid &&
                 (((state_q == S_ARMED) && trig_hit_c) || (state_q == S_CAPTURE));
    push_ok_c  = capture_c && (!full_c || pop_c);
    wr_entry_c = '{seq: seq_q, pc: commit_pc, instr: commit_instr,
                   rd: commit_rd, we: commit_we, wdata: commit_wdata};
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    seq_d    = seq_q;
    obs_d    = obs_q;
    drop_d   = drop_q;
    if (arm) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      seq_d    = '0;
      obs_d    = '0;
      drop_d   = '0;
    end else begin
      if (capture_c) begin
        seq_d = seq_q + SEQ_W'(1);
        obs_d = obs_q + 16'd1;
        // The commit that reaches the limit is still captured.
        if ((capture_limit != 16'd0) && (obs_d == capture_limit)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CAPTURE;
        end
        if (!push_ok_c && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
      end
      if (push_ok_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_c, pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
    valid_d = (level_d != '0);
    stall_d = STALL_ON_FULL && (state_d == S_CAPTURE) && (level_d == LVL_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      obs_q    <= '0;
      drop_q   <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      obs_q    <= obs_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
    end
  end

  // Storage; a full-plus-pop write lands in the slot being vacated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_c) begin
      mem_q[wr_ptr_q] <= wr_entry_c;
    end
  end

  assign {trace_seq, trace_pc, trace_instr, trace_rd, trace_we, trace_wdata} = mem_q[rd_ptr_q];
  assign trace_valid = valid_q;
  assign stall_req   = stall_q;
  assign state       = state_q;
  assign drop_cnt    = drop_q;
  assign level       = level_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench for commit_trace_buffer: drop-mode and stall-mode instances
// share stimulus and are compared every cycle against a queue-based model.
module tb_commit_trace_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [15:0] capture_limit = '0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_instr = '0;
  logic [4:0]  commit_rd = '0;
  logic        commit_we = 1'b0;
  logic [31:0] commit_wdata = '0;
  logic        trace_ready = 1'b0;

  logic             a_valid, b_valid;
  logic [15:0]      a_seq, b_seq;
  logic [31:0]      a_pc, b_pc, a_instr, b_instr, a_wdata, b_wdata;
  logic [4:0]       a_rd, b_rd;
  logic             a_we, b_we, a_stall, b_stall;
  logic [1:0]       a_state, b_state;
  logic [15:0]      a_drop, b_drop;
  logic [LVL_W-1:0] a_level, b_level;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .STALL_ON_FULL(1'b0), .SEQ_W(16)) u_drop (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .capture_limit(capture_limit), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_rd(commit_rd), .commit_we(commit_we),
    .commit_wdata(commit_wdata), .trace_valid(a_valid), .trace_ready(trace_ready),
    .trace_seq(a_seq), .trace_pc(a_pc), .trace_instr(a_instr), .trace_rd(a_rd),
    .trace_we(a_we), .trace_wdata(a_wdata), .stall_req(a_stall), .state(a_state),
    .drop_cnt(a_drop), .level(a_level)
  );

  commit_trace_buffer #(.DEPTH(DEPTH), .STALL_ON_FULL(1'b1), .SEQ_W(16)) u_stall (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .capture_limit(capture_limit), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_rd(commit_rd), .commit_we(commit_we),
    .commit_wdata(commit_wdata), .trace_valid(b_valid), .trace_ready(trace_ready),
    .trace_seq(b_seq), .trace_pc(b_pc), .trace_instr(b_instr), .trace_rd(b_rd),
    .trace_we(b_we), .trace_wdata(b_wdata), .stall_req(b_stall), .state(b_state),
    .drop_cnt(b_drop), .level(b_level)
  );

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
  } ent_t;

  // Reference model: 0 idle, 1 armed, 2 capture, 3 done.
  ent_t mq[$];
  int   mst = 0;
  int   mseq = 0;
  int   mobs = 0;
  int   mdrop = 0;
  logic [31:0] pc_ctr = '0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int st);
    mq.delete();
    mst   = st;
    mseq  = 0;
    mobs  = 0;
    mdrop = 0;
  endtask

  task automatic model_step();
    bit   pop, cap, acc;
    ent_t e;
    if (!rst) begin
      model_clear(0);
      return;
    end
    if (arm) begin
      model_clear(1);
      return;
    end
    pop = (mq.size() != 0) && trace_ready;
    cap = commit_valid && (((mst == 1) && (!trig_en || commit_pc == trig_pc)) || (mst == 2));
    acc = 1'b0;
    e   = '0;
    if (cap) begin
      e = '{seq: 16'(mseq), pc: commit_pc, instr: commit_instr, rd: commit_rd,
            we: commit_we, wdata: commit_wdata};
      mseq++;
      mobs++;
      mst = ((capture_limit != 16'd0) && (mobs == int'(capture_limit))) ? 3 : 2;
      acc = (mq.size() < int'(DEPTH)) || pop;
      if (!acc && mdrop < 65535) mdrop++;
    end
    if (pop) void'(mq.pop_front());
    if (cap && acc) mq.push_back(e);
  endtask

  task automatic check_all();
    bit full;
    full = (mq.size() == int'(DEPTH));
    check("state_drop",  128'(a_state), 128'(mst));
    check("state_stall", 128'(b_state), 128'(mst));
    check("level_drop",  128'(a_level), 128'(mq.size()));
    check("level_stall", 128'(b_level), 128'(mq.size()));
    check("valid_drop",  128'(a_valid), 128'(mq.size() != 0));
    check("valid_stall", 128'(b_valid), 128'(mq.size() != 0));
    check("drop_drop",   128'(a_drop),  128'(mdrop));
    check("drop_stall",  128'(b_drop),  128'(mdrop));
    check("stall_drop",  128'(a_stall), 128'(0));
    check("stall_stall", 128'(b_stall), 128'((mst == 2) && full));
    if (mq.size() != 0) begin
      check("head_drop",  128'({a_seq, a_pc, a_instr, a_rd, a_we, a_wdata}), 128'(mq[0]));
      check("head_stall", 128'({b_seq, b_pc, b_instr, b_rd, b_we, b_wdata}), 128'(mq[0]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_commit(input int prob);
    commit_valid = ($urandom_range(99) < prob);
    commit_pc    = pc_ctr;
    commit_instr = $urandom;
    commit_rd    = commit_instr[11:7];
    commit_we    = 1'($urandom_range(1));
    commit_wdata = $urandom;
    if (commit_valid) pc_ctr = (pc_ctr + 32'd4) & 32'h3F;
  endtask

  initial begin
    int lim, rp, cp;
    #1 rst = 1'b0;
    model_clear(0);
    repeat (2) cycle();
    rst = 1'b1;

    // Commits with no arm must leave the buffer idle and empty.
    repeat (12) begin
      rand_commit(100);
      trace_ready = 1'($urandom_range(1));
      cycle();
    end

    for (int s = 0; s < 30; s++) begin
      trig_en = 1'($urandom_range(1));
      trig_pc = 32'($urandom_range(15)) * 32'd4;
      case ($urandom_range(4))
        0:       lim = 0;
        1:       lim = 1;
        2:       lim = 4;
        3:       lim = 20;
        default: lim = $urandom_range(40, 1);
      endcase
      capture_limit = 16'(lim);
      case ($urandom_range(3))
        0:       rp = 0;
        1:       rp = 30;
        2:       rp = 70;
        default: rp = 100;
      endcase
      case ($urandom_range(2))
        0:       cp = 50;
        1:       cp = 90;
        default: cp = 100;
      endcase
      arm = 1'b1;
      rand_commit(cp);
      trace_ready = ($urandom_range(99) < rp);
      cycle();
      repeat (60) begin
        rand_commit(cp);
        trace_ready = ($urandom_range(99) < rp);
        arm = ($urandom_range(199) == 0);
        cycle();
      end
      arm = 1'b0;
      repeat (20) begin
        rand_commit(cp);
        trace_ready = 1'b1;
        cycle();
      end
    end

    // Asynchronous reset with data in flight.
    trig_en = 1'b0;
    capture_limit = 16'd0;
    trace_ready = 1'b0;
    arm = 1'b1;
    rand_commit(100);
    cycle();
    arm = 1'b0;
    repeat (3) begin
      rand_commit(100);
      cycle();
    end
    commit_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_valid_drop",  128'(a_valid), 128'(0));
    check("async_valid_stall", 128'(b_valid), 128'(0));
    check("async_state_drop",  128'(a_state), 128'(0));
    check("async_level_stall", 128'(b_level), 128'(0));
    model_clear(0);
    cycle();
    rst = 1'b1;
    repeat (5) begin
      rand_commit(100);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Hardware trace capture stage downstream of the beaver32rv single-cycle core.
- Samples the core's per-instruction retire information each clock: pc, instruction, rd, RegWrite and write-back data.
- Stores the samples in a FIFO and drains them through a valid/ready port to a host or debug reader.
- Provides arm/trigger/limit control, overflow accounting and an optional stall request back to the core.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2.
STALL_ON_FULL, 0, 1 = assert stall_req when full during capture; 0 = drop samples when full.
SEQ_W, 16, width of the per-entry sequence number.

Ports:
clk  in  1  rising-edge clock, shared with the core.
rst  in  1  asynchronous, active-low reset.
arm  in  1  pulse; flushes the FIFO and counters, enters ARMED.
trig_en  in  1  1 = wait for trig_pc match; 0 = start capture on the first commit after arm.
trig_pc  in  32  trigger address.
capture_limit  in  16  commits to observe before stopping; 0 = unlimited.
commit_valid  in  1  core retired an instruction this cycle.
commit_pc  in  32  pc of the retired instruction.
commit_instr  in  32  instruction word.
commit_rd  in  5  destination register (instruction[11:7]).
commit_we  in  1  RegWrite.
commit_wdata  in  32  register write-back data.
trace_valid  out  1  FIFO head is valid.
trace_ready  in  1  consumer accepts the head.
trace_seq  out  SEQ_W  head sequence number.
trace_pc  out  32  head field.
trace_instr  out  32  head field.
trace_rd  out  5  head field.
trace_we  out  1  head field.
trace_wdata  out  32  head field.
stall_req  out  1  request that the core hold its pc.
state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
drop_cnt  out  16  commits dropped while full; saturates at 0xFFFF.
level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous) sets every register and output to 0:
  - state=IDLE, trace_valid=0, stall_req=0, drop_cnt=0, level=0.
  - FIFO pointers and seq counter are cleared.
- State machine, updated on the rising clock edge:
  - IDLE -> ARMED on arm.
  - ARMED -> CAPTURE when commit_valid and (!trig_en or commit_pc==trig_pc). The triggering commit is itself captured as seq 0.
  - CAPTURE -> DONE when capture_limit!=0 and the observed-commit count reaches capture_limit. The final commit is captured.
  - DONE holds. The FIFO keeps draining.
  - An arm pulse in any state flushes the FIFO, clears seq and drop_cnt, and enters ARMED. Arm takes priority over every same-cycle event, and a commit in that cycle is ignored.
- Sequencing:
  - seq increments by 1 for every commit observed in CAPTURE, whether accepted or dropped.
  - seq wraps modulo 2^SEQ_W.
  - Dropped commits leave a gap in trace_seq.
- Push and pop:
  - A push is attempted when commit_valid and the commit is captured (see the state machine).
  - The push is accepted iff level<DEPTH, or a pop occurs in the same cycle. This means full + pop + push leaves level unchanged.
  - Pop occurs when trace_valid && trace_ready.
  - There is no bypass: a push into an empty FIFO gives trace_valid=1 on the next cycle (1-cycle latency).
  - trace_valid = (level!=0).
  - The head fields are stable while trace_valid && !trace_ready.
  - When valid=0 the head fields are don't-care.
  - Pointers wrap modulo DEPTH. level is exact, from 0 to DEPTH.
- Full handling:
  - A rejected push increments drop_cnt, saturating at 0xFFFF.
  - If STALL_ON_FULL=1: stall_req = (state==CAPTURE) && level==DEPTH. This is combinational from registered state, so there is no loop through commit_valid. A commit presented anyway while stall_req=1 is dropped and counted.
  - If STALL_ON_FULL=0, stall_req is always 0.
- Reset mid-capture discards all contents immediately. trace_valid falls asynchronously.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release; drive commits with no arm -> state=00, level=0, trace_valid=0, drop_cnt=0 throughout.
- Immediate capture: arm with trig_en=0 and limit=0; drive 3 commits with pc 0,4,8; trace_ready=1 -> trace_valid rises 1 cycle after the first commit; outputs are seq 0,1,2 with pc 0,4,8 and fields match the inputs.
- Trigger and limit: arm with trig_en=1, trig_pc=0x10, limit=4; drive pc 0,4,8,0xC,0x10,0x14,0x18,0x1C,0x20 -> FIFO holds pc 0x10..0x1C with seq 0..3; state=DONE after pc 0x1C; pc 0x20 is not stored.
- Overflow, DEPTH=16, STALL_ON_FULL=0: trace_ready=0 and 20 commits in CAPTURE -> level=16, drop_cnt=4; draining yields seq 0..15.
- Stall mode, STALL_ON_FULL=1: fill to 16 -> stall_req=1; pulse trace_ready for 1 cycle -> stall_req=0 next cycle, level=15; full + pop + push in the same cycle -> level stays 16, drop_cnt=0.
- Re-arm and async reset: with level=5, pulse arm -> next cycle level=0, seq restarts at 0. Assert rst=0 mid-cycle with level=3 -> trace_valid=0 and state=IDLE immediately, without waiting for a clock edge.
